// File: rtl/int_regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// Set REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module int_regfile_sb #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int NRPORT = 2,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRPORT*AW-1:0]     raddr_in,
    output logic [NRPORT*XLEN-1:0]   rdata_out,
    output logic [NRPORT-1:0]        rbusy_out,
    input  logic                     wen_in,
    input  logic [AW-1:0]            waddr_in,
    input  logic [XLEN-1:0]          wdata_in,
    input  logic                     iss_valid_in,
    input  logic [AW-1:0]            iss_rd_in,
    input  logic                     flush_in,
    output logic [AW:0]              busy_cnt_out,
    output logic                     wr_fault_out
);

    localparam logic [AW:0] LP_NREG = (AW+1)'(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;
    logic            r_fault;

    logic            w_wr_ok;
    logic            w_wr_bad;
    logic            w_iss_ok;
    logic            w_iss_bad;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;

    function automatic logic f_in_range(input logic [AW-1:0] a);
        return {1'b0, a} < LP_NREG;
    endfunction

    // Out-of-range addresses fault; x0 is silently ignored.
    assign w_wr_ok   = wen_in && (waddr_in != '0) && f_in_range(waddr_in);
    assign w_wr_bad  = wen_in && !f_in_range(waddr_in);
    assign w_iss_ok  = iss_valid_in && !flush_in && (iss_rd_in != '0) && f_in_range(iss_rd_in);
    assign w_iss_bad = iss_valid_in && !f_in_range(iss_rd_in);

    // Clear from writeback first so a same-cycle issue to the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush_in) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr_ok)
                w_busy_nxt[waddr_in] = 1'b0;
            if (w_iss_ok)
                w_busy_nxt[iss_rd_in] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_regs[waddr_in] <= wdata_in;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
            if (w_wr_bad || w_iss_bad)
                r_fault <= 1'b1;
        end
    end

    assign busy_cnt_out = r_busy_cnt;
    assign wr_fault_out = r_fault;

    for (genvar p = 0; p < NRPORT; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_ra_ok;
        logic [XLEN-1:0] w_rd;
        logic            w_rb;

        assign w_ra    = raddr_in[p*AW +: AW];
        assign w_ra_ok = (w_ra != '0) && f_in_range(w_ra);
`ifdef REGFILE_BYPASS_EN
        logic w_fwd;
        // w_wr_ok already excludes x0 and out-of-range addresses.
        assign w_fwd = w_wr_ok && (w_ra == waddr_in);
        assign w_rd  = w_fwd ? wdata_in
                             : (w_ra_ok ? r_regs[w_ra] : '0);
        assign w_rb  = w_fwd ? (w_iss_ok && (iss_rd_in == waddr_in))
                             : (w_ra_ok && r_busy[w_ra]);
`else
        assign w_rd  = w_ra_ok ? r_regs[w_ra] : '0;
        assign w_rb  = w_ra_ok && r_busy[w_ra];
`endif
        assign rdata_out[p*XLEN +: XLEN] = w_rd;
        assign rbusy_out[p]              = w_rb;
    end

endmodule

// File: tb/tb_int_regfile_sb.sv
// Directed bench for int_regfile_sb (NREG=24 so out-of-range addresses exist).
module tb_int_regfile_sb;

    localparam int XLEN   = 32;
    localparam int NREG   = 24;
    localparam int NRPORT = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NRPORT*AW-1:0]   raddr_in;
    logic [NRPORT*XLEN-1:0] rdata_out;
    logic [NRPORT-1:0]      rbusy_out;
    logic                   wen_in;
    logic [AW-1:0]          waddr_in;
    logic [XLEN-1:0]        wdata_in;
    logic                   iss_valid_in;
    logic [AW-1:0]          iss_rd_in;
    logic                   flush_in;
    logic [AW:0]            busy_cnt_out;
    logic                   wr_fault_out;

    int checks = 0;
    int errors = 0;

    int_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRPORT(NRPORT)) dut (
        .clk(clk), .rst(rst),
        .raddr_in(raddr_in), .rdata_out(rdata_out), .rbusy_out(rbusy_out),
        .wen_in(wen_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
        .iss_valid_in(iss_valid_in), .iss_rd_in(iss_rd_in), .flush_in(flush_in),
        .busy_cnt_out(busy_cnt_out), .wr_fault_out(wr_fault_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr_in = {a1, a0};
        #1;
    endtask

    task automatic idle();
        wen_in = 1'b0; iss_valid_in = 1'b0; flush_in = 1'b0;
    endtask

    logic r0_bad, r1_bad;

    initial begin
        rst = 1'b1; raddr_in = '0; waddr_in = '0; wdata_in = '0;
        iss_rd_in = '0; idle();
        #12;
        chk("rst_cnt", 32'(busy_cnt_out), 32'd0);
        chk("rst_fault", 32'(wr_fault_out), 32'd0);
        rst = 1'b0;
        step();

        // 1: all registers read zero and idle after reset
        r0_bad = 1'b0; r1_bad = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            setr(AW'(a), AW'(a));
            if (rdata_out !== '0 || rbusy_out !== '0) r0_bad = 1'b1;
        end
        chk("t1_all_zero", 32'(r0_bad), 32'd0);
        chk("t1_cnt", 32'(busy_cnt_out), 32'd0);

        // 2: plain write, x0 write ignored
        wen_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'hDEADBEEF;
        step(); idle();
        setr(5'd5, 5'd0);
        chk("t2_x5", rdata_out[31:0], 32'hDEADBEEF);
        wen_in = 1'b1; waddr_in = 5'd0; wdata_in = 32'hFFFFFFFF;
        step(); idle();
        setr(5'd0, 5'd0);
        chk("t2_x0_p0", rdata_out[31:0], 32'h0);
        chk("t2_x0_p1", rdata_out[63:32], 32'h0);

        // 3: issue marks busy, writeback clears it
        iss_valid_in = 1'b1; iss_rd_in = 5'd7;
        step(); idle();
        setr(5'd7, 5'd5);
        chk("t3_busy7", 32'(rbusy_out), 32'b01);
        chk("t3_cnt1", 32'(busy_cnt_out), 32'd1);
        wen_in = 1'b1; waddr_in = 5'd7; wdata_in = 32'h12;
        step(); idle();
        setr(5'd7, 5'd5);
        chk("t3_clear", 32'(rbusy_out), 32'b00);
        chk("t3_cnt0", 32'(busy_cnt_out), 32'd0);
        chk("t3_x7", rdata_out[31:0], 32'h12);

        // 4: same-cycle issue+write (set wins), then flush with stray issue/write
        iss_valid_in = 1'b1; iss_rd_in = 5'd3;
        wen_in = 1'b1; waddr_in = 5'd3; wdata_in = 32'hAA;
        step(); idle();
        iss_valid_in = 1'b1; iss_rd_in = 5'd10;
        step(); idle();
        setr(5'd3, 5'd10);
        chk("t4_x3", rdata_out[31:0], 32'hAA);
        chk("t4_busy", 32'(rbusy_out), 32'b11);
        chk("t4_cnt2", 32'(busy_cnt_out), 32'd2);
        flush_in = 1'b1; iss_valid_in = 1'b1; iss_rd_in = 5'd11;
        wen_in = 1'b1; waddr_in = 5'd12; wdata_in = 32'h77;
        step(); idle();
        setr(5'd12, 5'd11);
        chk("t4_flush_cnt", 32'(busy_cnt_out), 32'd0);
        chk("t4_flush_busy", 32'(rbusy_out), 32'b00);
        chk("t4_flush_wr", rdata_out[31:0], 32'h77);
        setr(5'd3, 5'd10);
        chk("t4_flush_busy2", 32'(rbusy_out), 32'b00);

        // 5: out-of-range write faults, sticky, changes nothing
        chk("t5_nofault", 32'(wr_fault_out), 32'd0);
        wen_in = 1'b1; waddr_in = 5'd25; wdata_in = 32'hBAD;
        step(); idle();
        setr(5'd5, 5'd25);
        chk("t5_fault", 32'(wr_fault_out), 32'd1);
        chk("t5_x5", rdata_out[31:0], 32'hDEADBEEF);
        chk("t5_oor_rd", rdata_out[63:32], 32'h0);
        chk("t5_oor_busy", 32'(rbusy_out), 32'b00);
        setr(5'd1, 5'd24);
        chk("t5_x1", rdata_out[31:0], 32'h0);
        step(); step();
        chk("t5_sticky", 32'(wr_fault_out), 32'd1);

        // 6: same-cycle read of a register being written
        iss_valid_in = 1'b1; iss_rd_in = 5'd9;
        step(); idle();
        setr(5'd0, 5'd9);
        chk("t6_busy9", 32'(rbusy_out[1]), 32'd1);
        wen_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("t6_same_data", rdata_out[63:32], 32'h55);
        chk("t6_same_busy", 32'(rbusy_out[1]), 32'd0);
`else
        chk("t6_same_data", rdata_out[63:32], 32'h0);
        chk("t6_same_busy", 32'(rbusy_out[1]), 32'd1);
`endif
        step(); idle();
        #1;
        chk("t6_next_data", rdata_out[63:32], 32'h55);
        chk("t6_next_busy", 32'(rbusy_out[1]), 32'd0);

        // reset during an in-flight write and issue
        wen_in = 1'b1; waddr_in = 5'd5; wdata_in = 32'h1234;
        iss_valid_in = 1'b1; iss_rd_in = 5'd4;
        #1 rst = 1'b1;
        step(); idle();
        rst = 1'b0;
        setr(5'd5, 5'd9);
        chk("rst_x5", rdata_out[31:0], 32'h0);
        chk("rst_x9", rdata_out[63:32], 32'h0);
        setr(5'd4, 5'd12);
        chk("rst_busy", 32'(rbusy_out), 32'b00);
        chk("rst_x12", rdata_out[63:32], 32'h0);
        chk("rst_cnt2", 32'(busy_cnt_out), 32'd0);
        chk("rst_fault2", 32'(wr_fault_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
